pokey_key_scan: RTL

Keyboard-scan sequencer for the POKEY controller path. It drives `key_scan_L` through all 64 key codes at a programmable step rate and samples the controller's `kr1_L`/`kr2_L` return lines. A four-state compare-latch debouncer confirms each key press, then raises `key_depr`, latches `keycode`/`shift` and pulses `key_irq` once per press. It sits between the POKEY register file (keycode readback, IRQ) and the controller interface, and is clocked from `o2`.

---
 rtl/pokey_key_scan.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pokey_key_scan.sv
// pokey_key_scan
// Keyboard-scan sequencer for the POKEY controller path. Walks a 6-bit scan
// counter through all 64 key codes at one step per LINE_DIV o2 cycles, samples
// the synchronized key return line once per step, and runs a four-state
// compare-latch debouncer that confirms presses and releases.
//
// Parameters:
//   LINE_DIV    o2 cycles per scan step, legal range 4..1023
// Ports:
//   o2          in   phase-2 system clock, rising edge
//   rst_L       in   asynchronous active-low reset
//   scan_en     in   1 = scanning runs, 0 = divider/counter/FSM hold
//   kr1_L       in   key return, low = addressed key closed (async)
//   kr2_L       in   shift/side-button return, low = active (async)
//   key_scan_L  out  active-low scan code (inverse of scan counter)
//   keycode     out  last confirmed key code
//   shift       out  inverted kr2_L, latched with keycode
//   key_depr    out  1 while a confirmed key is held
//   key_irq     out  one-cycle pulse per new confirmed press

module pokey_key_scan #(
   parameter int LINE_DIV = 114
) (
   input  logic       o2,
   input  logic       rst_L,
   input  logic       scan_en,
   input  logic       kr1_L,
   input  logic       kr2_L,
   output logic [5:0] key_scan_L,
   output logic [5:0] keycode,
   output logic       shift,
   output logic       key_depr,
   output logic       key_irq
);

   localparam int              DIV_W    = 10;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LINE_DIV - 1);

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   logic             kr1_meta_q, kr1_sync_q;
   logic             kr2_meta_q, kr2_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       ctr_q, ctr_d;
   logic [5:0]       cmp_q, cmp_d;
   state_t           state_q, state_d;
   logic [5:0]       keycode_q, keycode_d;
   logic             shift_q, shift_d;
   logic             key_depr_q, key_depr_d;
   logic             key_irq_q, key_irq_d;

   logic             sample;
   logic             hit;
   logic             key_closed;

   // Two-flop synchronizers for the asynchronous return lines. They idle
   // high (key open) out of reset and run regardless of scan_en.
   always_ff @(posedge o2 or negedge rst_L) begin
      if (!rst_L) begin
         kr1_meta_q <= 1'b1;
         kr1_sync_q <= 1'b1;
         kr2_meta_q <= 1'b1;
         kr2_sync_q <= 1'b1;
      end else begin
         kr1_meta_q <= kr1_L;
         kr1_sync_q <= kr1_meta_q;
         kr2_meta_q <= kr2_L;
         kr2_sync_q <= kr2_meta_q;
      end
   end

   // A sample point is the last divider cycle of a scan step. The FSM only
   // ever looks at the key line there, so the return path has most of the
   // step to settle after key_scan_L moves. "hit" narrows that further to the
   // step whose code matches the latched candidate key.
   assign sample     = scan_en && (div_q == DIV_LAST);
   assign hit        = sample && (ctr_q == cmp_q);
   assign key_closed = ~kr1_sync_q;

   // Divider, scan counter and debouncer next-state logic. Everything except
   // the IRQ pulse holds by default, which is what freezes the block while
   // scan_en is low; the IRQ defaults to 0 so an asserted pulse always ends
   // after one cycle even if scanning stops underneath it.
   always_comb begin
      div_d      = div_q;
      ctr_d      = ctr_q;
      cmp_d      = cmp_q;
      state_d    = state_q;
      keycode_d  = keycode_q;
      shift_d    = shift_q;
      key_depr_d = key_depr_q;
      key_irq_d  = 1'b0;

      if (scan_en) begin
         div_d = sample ? '0 : div_q + DIV_W'(1);
      end
      if (sample) begin
         ctr_d = ctr_q + 6'd1;
      end

      case (state_q)
         ST_WAIT: begin
            if (sample && key_closed) begin
               cmp_d   = ctr_q;
               state_d = ST_DEBOUNCE;
            end
         end
         // Second closed sample of the same code one full scan later
         // confirms the press; an open one was a glitch.
         ST_DEBOUNCE: begin
            if (hit) begin
               if (key_closed) begin
                  keycode_d  = cmp_q;
                  shift_d    = ~kr2_sync_q;
                  key_depr_d = 1'b1;
                  key_irq_d  = 1'b1;
                  state_d    = ST_HELD;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_HELD: begin
            if (hit && !key_closed) begin
               state_d = ST_RELEASE;
            end
         end
         // A release needs two consecutive open samples; a closed one in
         // between is contact bounce and quietly returns to HELD.
         ST_RELEASE: begin
            if (hit) begin
               if (key_closed) begin
                  state_d = ST_HELD;
               end else begin
                  key_depr_d = 1'b0;
                  state_d    = ST_WAIT;
               end
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // State register for divider, counter, debouncer and latched outputs.
   always_ff @(posedge o2 or negedge rst_L) begin
      if (!rst_L) begin
         div_q      <= '0;
         ctr_q      <= '0;
         cmp_q      <= '0;
         state_q    <= ST_WAIT;
         keycode_q  <= '0;
         shift_q    <= 1'b0;
         key_depr_q <= 1'b0;
         key_irq_q  <= 1'b0;
      end else begin
         div_q      <= div_d;
         ctr_q      <= ctr_d;
         cmp_q      <= cmp_d;
         state_q    <= state_d;
         keycode_q  <= keycode_d;
         shift_q    <= shift_d;
         key_depr_q <= key_depr_d;
         key_irq_q  <= key_irq_d;
      end
   end

   assign key_scan_L = ~ctr_q;
   assign keycode    = keycode_q;
   assign shift      = shift_q;
   assign key_depr   = key_depr_q;
   assign key_irq    = key_irq_q;

endmodule
